serial_adder_ctrl: RTL and testbench

//  Sequencer that reuses a single one_bit_LCA cell to perform a W-bit add bit-serially, LSB first.

---
 rtl/serial_adder_ctrl_if.sv | 40 ++++
 rtl/serial_adder_ctrl.sv | 175 +++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl_if
// Bundles the operand/result handshake of serial_adder_ctrl together with the
// wires to the shared one-bit adder cell.
//   master : operand source side; it also hosts the one-bit cell, so it drives
//            cell_c1 / cell_sum back to the sequencer.
//   slave  : the sequencer (serial_adder_ctrl).
// Signals:
//   start, a_in[W], b_in[W], cin       request and operands
//   busy, done, sum_out[W], cout       status and result
//   cell_a, cell_b, cell_c0            sequencer -> cell inputs
//   cell_c1, cell_sum                  cell -> sequencer (combinational)
// ----------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout;
  logic         cell_a;
  logic         cell_b;
  logic         cell_c0;
  logic         cell_c1;
  logic         cell_sum;

  modport master (
    output start, a_in, b_in, cin, cell_c1, cell_sum,
    input  busy, done, sum_out, cout, cell_a, cell_b, cell_c0
  );

  modport slave (
    input  start, a_in, b_in, cin, cell_c1, cell_sum,
    output busy, done, sum_out, cout, cell_a, cell_b, cell_c0
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial W-bit adder sequencer that time-shares one external one-bit adder
// cell. Operands are latched on an accepted start, one bit is processed per
// clock LSB first, the carry is registered between steps, and the result is
// presented with a one-cycle done pulse.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high
//   bus      serial_adder_ctrl_if.slave (start/a_in/b_in/cin in,
//            busy/done/sum_out/cout out, cell_a/cell_b/cell_c0 out,
//            cell_c1/cell_sum in)
// Parameters:
//   W            operand width (>= 1)
//   APPROX_BITS  number of approximate LSBs (0..W), only with APPROX_LSB_EN
// Configuration macro:
//   APPROX_LSB_EN  when defined, bits below APPROX_BITS bypass the cell and use
//                  sum = a|b, carry = a&b; otherwise every bit is exact.
// ----------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int W           = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int            CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  // Catch illegal configurations at elaboration time.
  if ((W < 1) || (APPROX_BITS < 0) || (APPROX_BITS > W)) begin : g_bad_cfg
    $error("serial_adder_ctrl: W must be >= 1 and APPROX_BITS within 0..W");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  sum_sh_r;
  logic [W-1:0]  sum_out_r;
  logic [CW-1:0] count_r;
  logic          carry_r;
  logic          cout_r;
  logic          busy_r;
  logic          done_r;

  logic          approx_s;
  logic          sum_bit_s;
  logic          carry_next_s;
  logic          cell_a_s;
  logic          cell_b_s;
  logic          cell_c0_s;
  logic [W-1:0]  sum_next_s;
  logic          unused_s;

  // Bit currently processed is approximate (only when the feature is built in).
`ifdef APPROX_LSB_EN
  assign approx_s = (int'(count_r) < APPROX_BITS);
`else
  assign approx_s = 1'b0;
`endif

  // Drive the shared cell only for exact bits while running; park it at 0 otherwise.
  always_comb begin
    cell_a_s  = 1'b0;
    cell_b_s  = 1'b0;
    cell_c0_s = 1'b0;
    if ((state_r == S_RUN) && !approx_s) begin
      cell_a_s  = a_r[0];
      cell_b_s  = b_r[0];
      cell_c0_s = carry_r;
    end else begin
      cell_a_s  = 1'b0;
      cell_b_s  = 1'b0;
      cell_c0_s = 1'b0;
    end
  end

  // Select the per-bit sum/carry source: OR/AND shortcut or the cell result.
  always_comb begin
    sum_bit_s    = 1'b0;
    carry_next_s = 1'b0;
    if (approx_s) begin
      sum_bit_s    = a_r[0] | b_r[0];
      carry_next_s = a_r[0] & b_r[0];
    end else begin
      sum_bit_s    = bus.cell_sum;
      carry_next_s = bus.cell_c1;
    end
  end

  // New bit enters at the MSB; after W steps bit 0 has reached position 0.
  if (W == 1) begin : g_sum_w1
    assign sum_next_s = sum_bit_s;
  end else begin : g_sum_wn
    assign sum_next_s = {sum_bit_s, sum_sh_r[W-1:1]};
  end

  // sum_sh_r[0] is always shifted out before it is needed.
  assign unused_s = sum_sh_r[0];

  // Sequencer FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
      sum_sh_r  <= {W{1'b0}};
      sum_out_r <= {W{1'b0}};
      count_r   <= {CW{1'b0}};
      carry_r   <= 1'b0;
      cout_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r      <= bus.a_in;
            b_r      <= bus.b_in;
            carry_r  <= bus.cin;
            count_r  <= {CW{1'b0}};
            sum_sh_r <= {W{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= S_RUN;
          end else begin
            busy_r   <= 1'b0;
          end
        end
        S_RUN: begin
          sum_sh_r <= sum_next_s;
          carry_r  <= carry_next_s;
          a_r      <= a_r >> 1'b1;
          b_r      <= b_r >> 1'b1;
          if (count_r == LAST_CNT) begin
            // Count stops at W-1, so it never wraps.
            sum_out_r <= sum_next_s;
            cout_r    <= carry_next_s;
            done_r    <= 1'b1;
            state_r   <= S_DONE;
          end else begin
            count_r   <= count_r + CW'(1);
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.sum_out = sum_out_r;
  assign bus.cout    = cout_r;
  assign bus.cell_a  = cell_a_s;
  assign bus.cell_b  = cell_b_s;
  assign bus.cell_c0 = cell_c0_s;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Self-checking bench for serial_adder_ctrl (W=8, APPROX_BITS=4). A one-bit
// full-adder cell is modelled on the cell_* wires. Expected results are
// computed by an independent bit-loop model when an add is issued, pushed to
// a queue, and popped when done is seen.
// ----------------------------------------------------------------------------
module tb_serial_adder_ctrl;
  localparam int W  = 8;
  localparam int AB = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.W(W)) bus ();

  serial_adder_ctrl #(.W(W), .APPROX_BITS(AB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One-bit adder cell shared by the sequencer.
  assign bus.cell_sum = bus.cell_a ^ bus.cell_b ^ bus.cell_c0;
  assign bus.cell_c1  = (bus.cell_a & bus.cell_b) | (bus.cell_c0 & (bus.cell_a ^ bus.cell_b));

  // Reference result {cout, sum}.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W-1:0] s;
    logic         cy;
    cy = c;
    for (int i = 0; i < W; i++) begin
`ifdef APPROX_LSB_EN
      if (i < AB) begin
        s[i] = a[i] | b[i];
        cy   = a[i] & b[i];
      end else
`endif
      begin
        s[i] = a[i] ^ b[i] ^ cy;
        cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
      end
    end
    return {cy, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge (edge 0) and record the expectation.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.cin   = c;
    bus.start = 1'b1;
    exp_q.push_back(model(a, b, c));
    step();
    bus.start = 1'b0;
  endtask

  // Advance until done is seen; cyc = edges taken, ok = 0 on timeout.
  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.done === 1'b1) begin
        cyc = i;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.cin   = 1'b0;
    step();
    step();
    checks++;
    if ({bus.busy, bus.done, bus.cout} !== 3'b000) begin
      fails++;
      $display("FAIL reset_status: got busy/done/cout=%b expected 000", {bus.busy, bus.done, bus.cout});
    end
    checks++;
    if (bus.sum_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_sum: got %h expected 00", bus.sum_out);
    end
    checks++;
    if ({bus.cell_a, bus.cell_b, bus.cell_c0} !== 3'b000) begin
      fails++;
      $display("FAIL reset_cell: got %b expected 000", {bus.cell_a, bus.cell_b, bus.cell_c0});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int         cyc;
    bit         ok;
    logic [W:0] exp;
    issue(8'hFF, 8'h01, 1'b0);
    wait_done(cyc, ok);
    checks++;
    if (!ok || cyc != W) begin
      fails++;
      $display("FAIL basic_latency: got %0d edges (ok=%0d) expected %0d", cyc, ok, W);
    end
    exp = exp_q.pop_front();
    checks++;
    if ({bus.cout, bus.sum_out} !== exp) begin
      fails++;
      $display("FAIL basic_result: got %h expected %h", {bus.cout, bus.sum_out}, exp);
    end
`ifndef APPROX_LSB_EN
    checks++;
    if ({bus.cout, bus.sum_out} !== 9'h100) begin
      fails++;
      $display("FAIL basic_const: got %h expected 100", {bus.cout, bus.sum_out});
    end
`endif
    step();
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      fails++;
      $display("FAIL basic_pulse: got done/busy=%b expected 00", {bus.done, bus.busy});
    end
    checks++;
    if ({bus.cout, bus.sum_out} !== exp) begin
      fails++;
      $display("FAIL basic_hold: got %h expected %h", {bus.cout, bus.sum_out}, exp);
    end
  endtask

  task automatic test_busy();
    logic [W:0]   prev;
    logic [W:0]   exp;
    logic [W-1:0] a;
    logic         exp_ca;
    a    = 8'h5A;
    prev = {bus.cout, bus.sum_out};
    issue(a, 8'hA5, 1'b1);
    for (int k = 0; k < W; k++) begin
      exp_ca = a[k];
`ifdef APPROX_LSB_EN
      if (k < AB) exp_ca = 1'b0;
`endif
      checks++;
      if ({bus.busy, bus.done} !== 2'b10) begin
        fails++;
        $display("FAIL busy_run bit %0d: got busy/done=%b expected 10", k, {bus.busy, bus.done});
      end
      checks++;
      if (bus.cell_a !== exp_ca) begin
        fails++;
        $display("FAIL cell_a bit %0d: got %b expected %b", k, bus.cell_a, exp_ca);
      end
      checks++;
      if ({bus.cout, bus.sum_out} !== prev) begin
        fails++;
        $display("FAIL run_hold bit %0d: got %h expected %h", k, {bus.cout, bus.sum_out}, prev);
      end
      step();
    end
    checks++;
    if ({bus.busy, bus.done} !== 2'b11) begin
      fails++;
      $display("FAIL busy_done: got busy/done=%b expected 11", {bus.busy, bus.done});
    end
    exp = exp_q.pop_front();
    checks++;
    if ({bus.cout, bus.sum_out} !== exp) begin
      fails++;
      $display("FAIL busy_result: got %h expected %h", {bus.cout, bus.sum_out}, exp);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_idle: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_ignore_start();
    int         cyc;
    bit         ok;
    logic [W:0] exp;
    issue(8'h3C, 8'h0F, 1'b0);
    step();
    step();
    bus.a_in  = 8'h11;
    bus.b_in  = 8'h22;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(cyc, ok);
    checks++;
    if (!ok || cyc != W - 3) begin
      fails++;
      $display("FAIL ignore_latency: got %0d edges (ok=%0d) expected %0d", cyc, ok, W - 3);
    end
    exp = exp_q.pop_front();
    checks++;
    if ({bus.cout, bus.sum_out} !== exp) begin
      fails++;
      $display("FAIL ignore_result: got %h expected %h", {bus.cout, bus.sum_out}, exp);
    end
    step();
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_no_restart: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_midrun();
    bit seen;
    issue(8'hFF, 8'hFF, 1'b1);
    void'(exp_q.pop_front());
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.cout} !== 3'b000) begin
      fails++;
      $display("FAIL abort_status: got busy/done/cout=%b expected 000", {bus.busy, bus.done, bus.cout});
    end
    checks++;
    if (bus.sum_out !== 8'h00) begin
      fails++;
      $display("FAIL abort_sum: got %h expected 00", bus.sum_out);
    end
    seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_done: got activity=%b expected 0", seen);
    end
  endtask

  task automatic test_approx();
    int         cyc;
    bit         ok;
    logic [W:0] exp;
    logic [W:0] fixed;
`ifdef APPROX_LSB_EN
    fixed = 9'h00F;
`else
    fixed = 9'h011;
`endif
    issue(8'h0F, 8'h01, 1'b1);
    wait_done(cyc, ok);
    checks++;
    if (!ok || cyc != W) begin
      fails++;
      $display("FAIL approx_latency: got %0d edges (ok=%0d) expected %0d", cyc, ok, W);
    end
    exp = exp_q.pop_front();
    checks++;
    if ({bus.cout, bus.sum_out} !== exp) begin
      fails++;
      $display("FAIL approx_result: got %h expected %h", {bus.cout, bus.sum_out}, exp);
    end
    checks++;
    if ({bus.cout, bus.sum_out} !== fixed) begin
      fails++;
      $display("FAIL approx_const: got %h expected %h", {bus.cout, bus.sum_out}, fixed);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av[3];
    logic [W-1:0] bv[3];
    logic         cv[3];
    int           cyc;
    bit           ok;
    logic [W:0]   exp;
    av[0] = 8'h80; bv[0] = 8'h80; cv[0] = 1'b0;
    av[1] = 8'h12; bv[1] = 8'h34; cv[1] = 1'b1;
    av[2] = 8'hAA; bv[2] = 8'h55; cv[2] = 1'b0;
    bus.a_in  = av[0];
    bus.b_in  = bv[0];
    bus.cin   = cv[0];
    bus.start = 1'b1;
    exp_q.push_back(model(av[0], bv[0], cv[0]));
    step();
    for (int j = 0; j < 3; j++) begin
      wait_done(cyc, ok);
      checks++;
      if (!ok || cyc != ((j == 0) ? W : W + 2)) begin
        fails++;
        $display("FAIL b2b_interval op %0d: got %0d edges (ok=%0d) expected %0d", j, cyc, ok, (j == 0) ? W : W + 2);
      end
      exp = exp_q.pop_front();
      checks++;
      if ({bus.cout, bus.sum_out} !== exp) begin
        fails++;
        $display("FAIL b2b_result op %0d: got %h expected %h", j, {bus.cout, bus.sum_out}, exp);
      end
      if (j < 2) begin
        bus.a_in = av[j+1];
        bus.b_in = bv[j+1];
        bus.cin  = cv[j+1];
        exp_q.push_back(model(av[j+1], bv[j+1], cv[j+1]));
      end else begin
        bus.start = 1'b0;
      end
    end
    step();
    checks++;
    if (bus.done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_pulse: got done=%b expected 0", bus.done);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy();
    test_ignore_start();
    test_reset_midrun();
    test_approx();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
